// File: rtl/hht_row_mac.sv
// rtl/hht_row_mac.sv - per-row multiply-accumulate of HHT (matrix, vector) pairs for SpMV
//
// Walks the CSR row_ptr array through a combinational read port, consumes
// each row's nonzero pairs from the HHT and emits one dot product per row.
//
// Ports:
//   Clk, Rst             clock (rising edge), synchronous active-high reset
//   start                one-cycle pulse, begins a run; ignored while busy
//   row_base, num_rows   address of row_ptr[0] and row count, sampled on start
//   rp_addr / rp_data    row-pointer read port, data valid in the same cycle
//   in_valid/in_ready    pair handshake; in_mval = matrix value, in_vval = vector value
//   y_valid/y_ready      result handshake; y_data = dot product, y_row = row index
//   busy, done, err      run in progress, end-of-run pulse, sticky malformed row_ptr flag

module hht_row_mac #(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int ACC_W = 64
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [AW-1:0]    row_base,
    input  logic [31:0]      num_rows,
    output logic [AW-1:0]    rp_addr,
    input  logic [31:0]      rp_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_mval,
    input  logic [DW-1:0]    in_vval,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [ACC_W-1:0] y_data,
    output logic [31:0]      y_row,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {IDLE, RP0, RPN, ACC, EMIT, DONE} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     base_q;
    logic [31:0]       nrows_q;
    logic [31:0]       r_q;
    logic [31:0]       prev_q;
    logic [31:0]       cnt_q;
    logic [ACC_W-1:0]  acc_q;
    logic              err_q;

    logic              in_fire;
    logic              y_fire;
    logic              rp_bad;
    logic [31:0]       rp_diff;
    logic              last_row;
    logic [2*DW-1:0]   prod;

    assign in_fire  = in_valid & in_ready;
    assign y_fire   = y_valid & y_ready;
    assign rp_bad   = rp_data < prev_q;
    assign rp_diff  = rp_data - prev_q;
    assign last_row = (r_q == nrows_q - 32'd1);
    // Full-width unsigned product; the accumulator wraps naturally.
    assign prod     = (2*DW)'(in_mval) * (2*DW)'(in_vval);

    assign y_data = acc_q;
    assign y_row  = r_q;
    assign err    = err_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (num_rows == 32'd0) ? DONE : RP0;
            RP0:  state_nxt = RPN;
            // A malformed (decreasing) pointer is treated as an empty row.
            RPN:  state_nxt = (rp_bad || rp_diff == 32'd0) ? EMIT : ACC;
            ACC:  if (in_fire && cnt_q == 32'd1) state_nxt = EMIT;
            EMIT: if (y_fire) state_nxt = last_row ? DONE : RPN;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rp_addr  = '0;
        in_ready = 1'b0;
        y_valid  = 1'b0;
        busy     = (state != IDLE);
        done     = (state == DONE);
        case (state)
            RP0:  rp_addr = base_q;
            RPN:  rp_addr = base_q + AW'(r_q) + AW'(1);
            // Gated by Rst so nothing is handed over in the reset cycle.
            ACC:  in_ready = ~Rst;
            EMIT: y_valid  = ~Rst;
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            base_q  <= '0;
            nrows_q <= '0;
            r_q     <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    base_q  <= row_base;
                    nrows_q <= num_rows;
                    err_q   <= 1'b0;
                    r_q     <= '0;
                    acc_q   <= '0;
                end
                RP0: prev_q <= rp_data;
                RPN: begin
                    prev_q <= rp_data;
                    acc_q  <= '0;
                    if (rp_bad) begin
                        err_q <= 1'b1;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= rp_diff;
                    end
                end
                ACC: if (in_fire) begin
                    acc_q <= acc_q + ACC_W'(prod);
                    cnt_q <= cnt_q - 32'd1;
                end
                EMIT: if (y_fire) begin
                    acc_q <= '0;
                    if (!last_row) r_q <= r_q + 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/hht_row_mac.md
Name: hht_row_mac

Overview:
Downstream consumer of the HHT control/gather engine in the sparse matrix-vector path. It takes the stream of (matrix value, gathered vector value) pairs produced by the HHT and reads the CSR row-pointer array itself through a combinational read port. It multiply-accumulates each row's nonzeros and emits one dot-product result per row (y[r]) over a valid/ready handshake to the result writer / CPU buffer.

Parameters:
DW, 32, width of matrix and vector values
AW, 32, memory address width
ACC_W, 64, accumulator and result width (≥ 2*DW)

Ports:
Clk  input  1  clock, rising edge
Rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins processing, ignored while busy=1
row_base  input  AW  address of row_ptr[0]; sampled on start
num_rows  input  32  number of rows; sampled on start
rp_addr  output  AW  row-pointer read address
rp_data  input  32  row-pointer data, valid in the same cycle as rp_addr (combinational memory)
in_valid  input  1  pair available from HHT
in_ready  output  1  pair accepted when in_valid & in_ready
in_mval  input  DW  matrix nonzero value
in_vval  input  DW  gathered vector value v[col[i]]
y_valid  output  1  row result valid
y_ready  input  1  result consumer ready
y_data  output  ACC_W  row dot product
y_row  output  32  row index of y_data
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse at end of run
err  output  1  sticky malformed row_ptr flag; cleared by start or Rst

Behaviour:
- Interface: one clock Clk; reset Rst is synchronous, active-high.
- Reset (any state, including mid-run): state=IDLE; in_ready, y_valid, busy, done, err = 0; y_data, y_row, rp_addr, acc, row counter, nz count = 0. Pairs offered during reset are not consumed.
- FSM states: IDLE, RP0, RPN, ACC, EMIT, DONE.
- IDLE: on start, latch row_base and num_rows, clear err, r=0, acc=0. Go to DONE if num_rows==0, else RP0.
- RP0 (1 cycle): rp_addr=row_base; latch prev=rp_data; go to RPN.
- RPN (1 cycle): rp_addr=row_base+r+1; cnt=rp_data-prev; prev<=rp_data.
  - If rp_data<prev: set err, cnt=0.
  - If cnt==0, go to EMIT (acc=0); else go to ACC.
- ACC: in_ready=1. Each accepted pair does acc <= acc + zero_extend(in_mval*in_vval), unsigned, full 2*DW product, wrapping mod 2^ACC_W, and decrements cnt. On acceptance of the last pair (cnt==1) go to EMIT next cycle; y_data includes that last product. With in_valid low the block holds state indefinitely.
- EMIT: y_valid=1, y_data=acc, y_row=r. Outputs are stable while y_ready=0. On y_valid&y_ready: acc<=0; if r==num_rows-1 go to DONE, else r<=r+1 and go to RPN.
- DONE: done=1 for exactly one cycle, busy=0 next, return to IDLE.
- in_ready=0 in every state except ACC. y_valid=0 in every state except EMIT.
- Throughput: 1 pair/cycle in ACC. Per-row overhead is 1 cycle (RPN) plus ≥1 cycle (EMIT).
- start asserted while busy: ignored, with no effect on the current run.

Test Plan:
1. row_base=40, mem[40..43]={0,2,2,5}, num_rows=3; pairs (3,4),(5,2),(1,7),(2,2),(10,1), in_valid held high, y_ready=1 -> y sequence (row0,22),(row1,0),(row2,21); exactly 5 pairs consumed; one done pulse; err=0.
2. Same as 1 but y_ready=0 for 5 cycles at row0 EMIT -> y_valid held, y_data=22 and y_row=0 stable; in_ready=0 throughout; row1 follows after release.
3. Bubbles: in_valid toggled 1,0,0,1 during row0 of scenario 1 -> result still 22; in_ready high throughout ACC; no extra pairs consumed.
4. Overflow: mem={0,2}, num_rows=1, pairs (0xFFFFFFFF,0xFFFFFFFF) twice -> y_data=0xFFFFFFFC00000002.
5. Malformed: mem={5,3}, num_rows=1 -> err=1, y_data=0, no pairs consumed, done pulses. A subsequent start clears err.
6. Rst asserted for 1 cycle during ACC of row2 in scenario 1 -> next cycle all outputs 0, state IDLE. A fresh start reruns scenario 1 with correct results. num_rows=0 -> done one cycle after start, no y_valid.
